// File: rtl/div_clk_monitor.sv
// div_clk_monitor
//   Receive-side checker for an odd-ratio, 50%-duty divided clock. The divided clock is
//   synchronised onto the fast source clock, and the monitor measures its period and high time.
//   It declares lock after LOCK_CNT consecutive good periods and flags ratio, duty and
//   stuck-clock faults.
//
// Ports
//   clk          in   source (undivided) clock; all logic on posedge
//   rst          in   asynchronous, active-high reset
//   en           in   monitor enable; low holds the monitor in WAIT with counters cleared
//   div_in       in   divided clock under test (asynchronous, synchronised here)
//   locked       out  high while in LOCKED state
//   meas_valid   out  1-cycle pulse when meas_period/meas_high update
//   meas_period  out  last measured period in clk cycles
//   meas_high    out  clk cycles div_in was sampled high within that period
//   err_pulse    out  1-cycle pulse on a bad period, bad duty or timeout
//   timeout      out  sticky stuck-clock flag; cleared by the next rise, en low or rst

module div_clk_monitor #(
  parameter int unsigned DIV      = 5,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  output logic             locked,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             err_pulse,
  output logic             timeout
);

  localparam int unsigned GoodW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] SatVal  = CNT_W'(2 * DIV);
  localparam logic [CNT_W-1:0] DivVal  = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] HighLo  = CNT_W'(DIV >> 1);
  localparam logic [CNT_W-1:0] HighHi  = CNT_W'((DIV + 1) >> 1);
  localparam logic [GoodW-1:0] LockVal = GoodW'(LOCK_CNT);
  localparam logic [GoodW-1:0] LockPre = GoodW'(LOCK_CNT - 1);

  localparam logic [1:0] StWait   = 2'd0;
  localparam logic [1:0] StAcq    = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       state_q, state_d;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] meas_period_q, meas_period_d;
  logic [CNT_W-1:0] meas_high_q, meas_high_d;
  logic             meas_valid_q, meas_valid_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;

  logic rise;
  logic is_good;
  logic stuck;

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= div_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  // Counters hold the just-finished period's values on the rise cycle, before reload.
  assign is_good = (period_cnt_q == DivVal) &&
                   ((high_cnt_q == HighLo) || (high_cnt_q == HighHi));
  assign stuck   = (period_cnt_q == SatVal);

  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    meas_period_d = meas_period_q;
    meas_high_d   = meas_high_q;
    meas_valid_d  = 1'b0;
    err_d         = 1'b0;
    timeout_d     = timeout_q;

    if (!en) begin
      state_d      = StWait;
      good_cnt_d   = '0;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      timeout_d    = 1'b0;
    end else begin
      if (rise) begin
        period_cnt_d = CNT_W'(1);
        high_cnt_d   = CNT_W'(1);
      end else begin
        if (!stuck) begin
          period_cnt_d = period_cnt_q + 1'b1;
        end
        if (s2_q && (high_cnt_q != SatVal)) begin
          high_cnt_d = high_cnt_q + 1'b1;
        end
      end

      if (rise) begin
        timeout_d = 1'b0;
        if (state_q == StWait) begin
          // First partial period after WAIT is never measured.
          state_d    = StAcq;
          good_cnt_d = '0;
        end else begin
          meas_valid_d  = 1'b1;
          meas_period_d = period_cnt_q;
          meas_high_d   = high_cnt_q;
          if (is_good) begin
            case (state_q)
              StAcq: begin
                if (good_cnt_q == LockPre) begin
                  state_d    = StLocked;
                  good_cnt_d = LockVal;
                end else begin
                  good_cnt_d = good_cnt_q + 1'b1;
                end
              end
              StLocked: state_d = StLocked;
              default:  state_d = StWait;
            endcase
          end else begin
            err_d      = 1'b1;
            good_cnt_d = '0;
            state_d    = StAcq;
          end
        end
      end else if ((state_q != StWait) && stuck) begin
        state_d    = StWait;
        good_cnt_d = '0;
        timeout_d  = 1'b1;
        err_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StWait;
      good_cnt_q    <= '0;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      meas_period_q <= '0;
      meas_high_q   <= '0;
      meas_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      meas_period_q <= meas_period_d;
      meas_high_q   <= meas_high_d;
      meas_valid_q  <= meas_valid_d;
      err_q         <= err_d;
      timeout_q     <= timeout_d;
    end
  end

  assign locked      = (state_q == StLocked);
  assign meas_valid  = meas_valid_q;
  assign meas_period = meas_period_q;
  assign meas_high   = meas_high_q;
  assign err_pulse   = err_q;
  assign timeout     = timeout_q;

endmodule
